// File: rtl/alioth_tohost_ctrl_if.sv
// alioth_tohost_ctrl_if: single-outstanding request/response bus
// between the SoC peripheral master and the tohost responder.
interface alioth_tohost_ctrl_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [31:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_rdata_o;

  modport slave (
    input  req_valid_i,
    input  req_we_i,
    input  req_addr_i,
    input  req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o,
    output rsp_valid_o,
    output rsp_rdata_o
  );

  modport master (
    output req_valid_i,
    output req_we_i,
    output req_addr_i,
    output req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o,
    input  rsp_valid_o,
    input  rsp_rdata_o
  );
endinterface

// File: rtl/alioth_tohost_ctrl.sv
// alioth_tohost_ctrl: tohost end-of-test responder with cycle capture.
// Optional PUTC console port at 0x10 enabled by ALIOTH_TOHOST_PUTC_EN.
module alioth_tohost_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int CYC_WIDTH   = 64,
  parameter int TIMEOUT_BIT = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alioth_tohost_ctrl_if.slave  bus,
  output logic                 test_done_o,
  output logic                 test_pass_o,
  output logic [30:0]          fail_testnum_o,
  output logic [CYC_WIDTH-1:0] end_cycle_o,
  output logic                 timeout_o
`ifdef ALIOTH_TOHOST_PUTC_EN
  ,
  output logic                 putc_valid_o,
  output logic [7:0]           putc_data_o
`endif
);

  typedef enum logic [1:0] {
    RUN,
    DONE,
    TMO
  } state_t;

  state_t state_q, state_d;

  logic [CYC_WIDTH-1:0]  cnt_q;
  logic [63:0]           cnt_ext;
  logic [31:0]           tohost_q;
  logic [31:0]           rdata_d;
  logic [31:0]           rdata_q;
  logic                  rsp_valid_q;
  logic                  init_q;
  logic [ADDR_WIDTH-1:0] word;
  logic                  accept;
  logic                  wr;
  logic                  hit_tohost;
  logic                  hit_lo;
  logic                  hit_hi;
  logic                  hit_status;
  logic                  done_evt;
  logic                  tmo_cond;
  logic                  done_q;
  logic                  pass_q;
  logic                  tmo_q;
  logic [30:0]           fail_q;
  logic [CYC_WIDTH-1:0]  end_q;

  assign word       = bus.req_addr_i >> 2;
  assign hit_tohost = word == ADDR_WIDTH'(0);
  assign hit_lo     = word == ADDR_WIDTH'(1);
  assign hit_hi     = word == ADDR_WIDTH'(2);
  assign hit_status = word == ADDR_WIDTH'(3);

  // ready stays low for the first cycle out of reset
  assign bus.req_ready_o = init_q & (~rsp_valid_q | bus.rsp_ready_i);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rdata_q;

  assign accept = bus.req_valid_i & bus.req_ready_o;
  assign wr     = accept & bus.req_we_i;

  assign done_evt = (state_q == RUN) & wr & hit_tohost
                  & bus.req_wdata_i[0];

  generate
    if (TIMEOUT_BIT != 0 && TIMEOUT_BIT < CYC_WIDTH) begin : g_tmo
      assign tmo_cond = cnt_q[TIMEOUT_BIT];
    end else begin : g_no_tmo
      assign tmo_cond = 1'b0;
    end
    if (CYC_WIDTH >= 64) begin : g_ext_full
      assign cnt_ext = cnt_q[63:0];
    end else begin : g_ext_pad
      assign cnt_ext = {{(64-CYC_WIDTH){1'b0}}, cnt_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (done_evt)      state_d = DONE;
        else if (tmo_cond) state_d = TMO;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (!bus.req_we_i) begin
      unique case (1'b1)
        hit_tohost: rdata_d = tohost_q;
        hit_lo:     rdata_d = cnt_ext[31:0];
        hit_hi:     rdata_d = cnt_ext[63:32];
        hit_status: rdata_d = {28'b0, tmo_q, pass_q, done_q,
                               state_q == RUN};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      init_q <= 1'b1;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rdata_q     <= rdata_d;
      end else if (bus.rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost_q <= '0;
    end else if (wr && hit_tohost) begin
      tohost_q <= bus.req_wdata_i;
    end
  end

  // done wins over a same-cycle timeout; both are terminal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tmo_q  <= 1'b0;
      fail_q <= '0;
      end_q  <= '0;
    end else if (done_evt) begin
      done_q <= 1'b1;
      pass_q <= bus.req_wdata_i == 32'd1;
      fail_q <= bus.req_wdata_i[31:1];
      end_q  <= cnt_q;
    end else if (state_q == RUN && tmo_cond) begin
      tmo_q <= 1'b1;
    end
  end

  assign test_done_o    = done_q;
  assign test_pass_o    = pass_q;
  assign fail_testnum_o = fail_q;
  assign end_cycle_o    = end_q;
  assign timeout_o      = tmo_q;

`ifdef ALIOTH_TOHOST_PUTC_EN
  logic       hit_putc;
  logic       putc_valid_q;
  logic [7:0] putc_data_q;

  assign hit_putc = word == ADDR_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      putc_valid_q <= 1'b0;
      putc_data_q  <= '0;
    end else begin
      putc_valid_q <= wr & hit_putc;
      if (wr && hit_putc) putc_data_q <= bus.req_wdata_i[7:0];
    end
  end

  assign putc_valid_o = putc_valid_q;
  assign putc_data_o  = putc_data_q;
`endif

endmodule

// File: tb/tb_alioth_tohost_ctrl.sv
// tb_alioth_tohost_ctrl: scoreboard bench for the tohost responder,
// with a second instance built for a short timeout.
module tb_alioth_tohost_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  always #5 clk = ~clk;

  alioth_tohost_ctrl_if #(.ADDR_WIDTH(8)) bus ();
  alioth_tohost_ctrl_if #(.ADDR_WIDTH(8)) bus2 ();

  logic        done, pass, tmo;
  logic [30:0] fnum;
  logic [63:0] endc;
  logic        done2, pass2, tmo2;
  logic [30:0] fnum2;
  logic [63:0] endc2;
`ifdef ALIOTH_TOHOST_PUTC_EN
  logic       putc_v, putc_v2;
  logic [7:0] putc_d, putc_d2;
`endif

  alioth_tohost_ctrl #(
    .ADDR_WIDTH(8), .CYC_WIDTH(64), .TIMEOUT_BIT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .test_done_o(done), .test_pass_o(pass),
    .fail_testnum_o(fnum), .end_cycle_o(endc),
    .timeout_o(tmo)
`ifdef ALIOTH_TOHOST_PUTC_EN
    , .putc_valid_o(putc_v), .putc_data_o(putc_d)
`endif
  );

  alioth_tohost_ctrl #(
    .ADDR_WIDTH(8), .CYC_WIDTH(64), .TIMEOUT_BIT(4)
  ) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2.slave),
    .test_done_o(done2), .test_pass_o(pass2),
    .fail_testnum_o(fnum2), .end_cycle_o(endc2),
    .timeout_o(tmo2)
`ifdef ALIOTH_TOHOST_PUTC_EN
    , .putc_valid_o(putc_v2), .putc_data_o(putc_d2)
`endif
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t q[$];

  logic [63:0] m_cnt;
  logic        m_run;
  logic        m_stop = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // counter model: runs until the cycle after a done write is accepted
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= '0;
      m_run <= 1'b1;
    end else begin
      if (m_run)  m_cnt <= m_cnt + 1;
      if (m_stop) m_run <= 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_rdata_o, 64'hx);
      end else begin
        e = q.pop_front();
        chk(e.tag, bus.rsp_rdata_o, e.exp);
      end
    end
  end

  task automatic bus_op(input string tag, input logic we,
                        input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input bit use_cnt,
                        output logic [63:0] acc);
    int   n;
    exp_t e;
    acc = '0;
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wd;
    #1;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready_o) begin
      chk({tag, "_accept"}, 0, 1);
      bus.req_valid_i = 1'b0;
      return;
    end
    acc   = m_cnt;
    e.tag = tag;
    e.exp = use_cnt ? m_cnt[31:0] : exp;
    q.push_back(e);
    if (we && addr == 8'h00 && wd[0]) m_stop = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    q.delete();
    rst_n = 1'b0;
    m_stop = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("rst_outs", {done, pass, tmo, bus.rsp_valid_o}, 0);
    chk("rst_fail", fnum, 0);
    chk("rst_end", endc, 0);
    chk("rst_rdata", bus.rsp_rdata_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_rel", bus.req_ready_o, 0);
    @(negedge clk);
    #1;
    chk("ready_1cyc", bus.req_ready_o, 1);
  endtask

  task automatic rd2(input string tag, input logic [7:0] addr,
                     input logic [31:0] exp);
    @(negedge clk);
    bus2.req_valid_i = 1'b1;
    bus2.req_we_i    = 1'b0;
    bus2.req_addr_i  = addr;
    #1;
    chk({tag, "_ready"}, bus2.req_ready_o, 1);
    @(negedge clk);
    bus2.req_valid_i = 1'b0;
    #1;
    chk({tag, "_valid"}, bus2.rsp_valid_o, 1);
    chk(tag, bus2.rsp_rdata_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] acc;
    int          n;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_addr_i   = '0;
    bus.req_wdata_i  = '0;
    bus.rsp_ready_i  = 1'b1;
    bus2.req_valid_i = 1'b0;
    bus2.req_we_i    = 1'b0;
    bus2.req_addr_i  = '0;
    bus2.req_wdata_i = '0;
    bus2.rsp_ready_i = 1'b1;

    // scenario 1: register map, pass completion at cycle 100
    do_reset();
    bus_op("status_run", 0, 8'h0C, 0, 32'h1, 0, acc);
    bus_op("cycle_hi", 0, 8'h08, 0, 32'h0, 0, acc);
    bus_op("unmapped_rd", 0, 8'h14, 0, 32'h0, 0, acc);
    bus_op("unmapped_wr", 1, 8'h14, 32'hDEAD, 32'h0, 0, acc);
    bus_op("tohost_wr0", 1, 8'h00, 32'h6, 32'h0, 0, acc);
    bus_op("tohost_rd6", 0, 8'h03, 0, 32'h6, 0, acc);
    bus_op("status_still", 0, 8'h0C, 0, 32'h1, 0, acc);
`ifdef ALIOTH_TOHOST_PUTC_EN
    bus_op("putc_wr", 1, 8'h10, 32'h141, 32'h0, 0, acc);
    #1;
    chk("putc_valid", putc_v, 1);
    chk("putc_data", putc_d, 8'h41);
    @(negedge clk);
    #1;
    chk("putc_pulse", putc_v, 0);
`else
    bus_op("putc_unmapped", 0, 8'h10, 0, 32'h0, 0, acc);
`endif
    bus_op("cycle_lo_live", 0, 8'h04, 0, 0, 1, acc);
    n = 0;
    while (m_cnt < 100 && n < 500) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("no_timeout", tmo, 0);
    bus_op("done_wr", 1, 8'h00, 32'h1, 32'h0, 0, acc);
    #1;
    chk("pass_done", done, 1);
    chk("pass_pass", pass, 1);
    chk("pass_fnum", fnum, 0);
    chk("end_cycle", endc, acc);
    chk("end_cycle_100", endc, 100);
    repeat (4) @(negedge clk);
    bus_op("cycle_frozen", 0, 8'h04, 0, 0, 1, acc);
    bus_op("status_pass", 0, 8'h0C, 0, 32'h6, 0, acc);
    repeat (3) @(negedge clk);
    bus_op("cycle_frozen2", 0, 8'h04, 0, 32'd101, 0, acc);
    drain();

    // scenario 2: response back-pressure, then fail completion
    do_reset();
    bus.rsp_ready_i = 1'b0;
    bus_op("stall_rd1", 0, 8'h0C, 0, 32'h1, 0, acc);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", bus.rsp_valid_o, 1);
      chk("stall_rdata", bus.rsp_rdata_o, 1);
      chk("stall_ready", bus.req_ready_o, 0);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    #1;
    chk("ready_on_rsp", bus.req_ready_o, 1);
    begin
      exp_t e;
      e.tag = "stall_rd2";
      e.exp = 32'h0;
      q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus_op("fail_wr", 1, 8'h00, 32'h7, 32'h0, 0, acc);
    #1;
    chk("fail_done", done, 1);
    chk("fail_pass", pass, 0);
    chk("fail_fnum", fnum, 3);
    bus_op("late_wr", 1, 8'h00, 32'h1, 32'h0, 0, acc);
    #1;
    chk("late_done", done, 1);
    chk("late_pass", pass, 0);
    chk("late_fnum", fnum, 3);
    bus_op("late_tohost", 0, 8'h00, 0, 32'h1, 0, acc);
    bus_op("status_fail", 0, 8'h0C, 0, 32'h2, 0, acc);
    drain();

    // scenario 3: timeout instance, TIMEOUT_BIT=4
    @(negedge clk);
    rst2_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      if (k == 16) chk("tmo_c16", tmo2, 0);
      if (k == 17) chk("tmo_c17", tmo2, 1);
    end
    chk("tmo_done", done2, 0);
    rd2("tmo_status", 8'h0C, 32'h8);
    rd2("tmo_cycle", 8'h04, 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
